// File: rtl/ddu_pkg.sv
// Shared types and defaults for the debug-unit run controller.
package ddu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STEP_HI = 2'd2
   } clk_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 10;
   localparam int DEF_ADDR_WIDTH      = 8;

   function automatic int db_cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

   localparam int DB_CNT_W = db_cnt_width(DEF_DEBOUNCE_CYCLES);

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, debouncer and
// registered rise pulse.
module btn_debounce
   import ddu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int CNT_W = db_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             db_lvl;
   logic             db_lvl_q;
   logic             rise_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_lvl <= 1'b0;
         cnt    <= '0;
      end else if (sync_b == db_lvl) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         db_lvl <= sync_b;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // level is the delayed copy so it lines up with the rise pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_lvl_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         db_lvl_q <= db_lvl;
         rise_q   <= db_lvl & ~db_lvl_q;
      end
   end

   assign level = db_lvl_q;
   assign rise  = rise_q;

endmodule

// File: rtl/ddu_run_ctrl.sv
// Debug-unit run controller: gated CPU clock (run/step) and the
// debug read address driven by the board buttons.
module ddu_run_ctrl
   import ddu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
   input  logic                  clk_500,
   input  logic                  rst,
   input  logic                  cont,
   input  logic                  step,
   input  logic                  inc,
   input  logic                  dec,
   input  logic [31:0]           pc_addr,
   output logic                  cpu_clk,
   output logic [ADDR_WIDTH-1:0] ddu_raddr,
   output logic [15:0]           led
);

   logic cont_lvl;
   logic cont_rise_unused;
   logic step_lvl_unused;
   logic inc_lvl_unused;
   logic dec_lvl_unused;
   logic step_p;
   logic inc_p;
   logic dec_p;
   logic unused_pc;

   clk_state_t state;
   clk_state_t state_n;
   logic       clk_n;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont (
      .clk   (clk_500),
      .rst   (rst),
      .btn   (cont),
      .level (cont_lvl),
      .rise  (cont_rise_unused)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk   (clk_500),
      .rst   (rst),
      .btn   (step),
      .level (step_lvl_unused),
      .rise  (step_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk   (clk_500),
      .rst   (rst),
      .btn   (inc),
      .level (inc_lvl_unused),
      .rise  (inc_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
      .clk   (clk_500),
      .rst   (rst),
      .btn   (dec),
      .level (dec_lvl_unused),
      .rise  (dec_p)
   );

   always_ff @(posedge clk_500 or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cpu_clk <= 1'b0;
      end else begin
         state   <= state_n;
         cpu_clk <= clk_n;
      end
   end

   // leaving RUN forces the clock low so no partial high phase survives
   always_comb begin
      state_n = state;
      clk_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (cont_lvl) begin
               state_n = RUN;
               clk_n   = 1'b1;
            end else if (step_p) begin
               state_n = STEP_HI;
               clk_n   = 1'b1;
            end
         end
         RUN: begin
            if (!cont_lvl) begin
               state_n = IDLE;
            end else begin
               clk_n = ~cpu_clk;
            end
         end
         STEP_HI: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_500 or posedge rst) begin
      if (rst) begin
         ddu_raddr <= '0;
      end else if (inc_p && !dec_p) begin
         ddu_raddr <= ddu_raddr + ADDR_WIDTH'(1);
      end else if (dec_p && !inc_p) begin
         ddu_raddr <= ddu_raddr - ADDR_WIDTH'(1);
      end
   end

   assign led = {ddu_raddr[7:0], pc_addr[9:2]};

   assign unused_pc = ^{pc_addr[31:10], pc_addr[1:0],
                        cont_rise_unused, step_lvl_unused,
                        inc_lvl_unused, dec_lvl_unused};

endmodule

// File: tb/tb_ddu_run_ctrl.sv
// Scoreboard bench for ddu_run_ctrl with DEBOUNCE_CYCLES = 4.
module tb_ddu_run_ctrl;

   typedef struct {
      int         at_edge;
      logic       clk;
      logic [7:0] addr;
   } exp_t;

   logic        clk_500 = 1'b0;
   logic        rst     = 1'b1;
   logic        cont    = 1'b0;
   logic        step    = 1'b0;
   logic        inc     = 1'b0;
   logic        dec     = 1'b0;
   logic [31:0] pc_addr = 32'h0000_0104;
   logic        cpu_clk;
   logic [7:0]  ddu_raddr;
   logic [15:0] led;

   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   exp_t exp_q[$];
   logic [7:0] model = 8'h00;
   logic       prev_clk;
   logic [7:0] prev_addr;

   ddu_run_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .ADDR_WIDTH      (8)
   ) dut (
      .clk_500   (clk_500),
      .rst       (rst),
      .cont      (cont),
      .step      (step),
      .inc       (inc),
      .dec       (dec),
      .pc_addr   (pc_addr),
      .cpu_clk   (cpu_clk),
      .ddu_raddr (ddu_raddr),
      .led       (led)
   );

   always #5 clk_500 = ~clk_500;

   always @(posedge clk_500) edge_n++;

   // monitor: every output change must match the head of the queue
   always @(negedge clk_500) begin
      exp_t e;
      if (rst) begin
         prev_clk  = cpu_clk;
         prev_addr = ddu_raddr;
      end else if (cpu_clk !== prev_clk || ddu_raddr !== prev_addr) begin
         prev_clk  = cpu_clk;
         prev_addr = ddu_raddr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: edge %0d cpu_clk %b addr %h, none required",
                     edge_n, cpu_clk, ddu_raddr);
         end else begin
            e = exp_q.pop_front();
            if (e.at_edge != edge_n || e.clk !== cpu_clk || e.addr !== ddu_raddr) begin
               errors++;
               $display("FAIL output_event: got edge %0d clk %b addr %h, required edge %0d clk %b addr %h",
                        edge_n, cpu_clk, ddu_raddr, e.at_edge, e.clk, e.addr);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input int at, input logic c, input logic [7:0] a);
      exp_t e;
      e.at_edge = at;
      e.clk     = c;
      e.addr    = a;
      exp_q.push_back(e);
   endtask

   task automatic press(input logic do_inc, input logic do_dec);
      int n;
      logic [7:0] nx;
      @(negedge clk_500);
      n   = edge_n;
      inc = do_inc;
      dec = do_dec;
      nx  = model;
      if (do_inc && !do_dec) nx = model + 8'd1;
      if (do_dec && !do_inc) nx = model - 8'd1;
      if (nx != model) push(n + 8, 1'b0, nx);
      model = nx;
      repeat (8) @(negedge clk_500);
      inc = 1'b0;
      dec = 1'b0;
      repeat (8) @(negedge clk_500);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk_500);
      chk("reset_cpu_clk", 32'(cpu_clk), 32'h0);
      chk("reset_raddr", 32'(ddu_raddr), 32'h0);
      chk("led_reset", 32'(led), 32'h0041);
      @(negedge clk_500);
      #2 rst = 1'b0;

      // single step: high only between edges 7 and 8
      @(negedge clk_500);
      n    = edge_n;
      step = 1'b1;
      push(n + 8, 1'b1, model);
      push(n + 9, 1'b0, model);
      repeat (10) @(negedge clk_500);
      step = 1'b0;
      repeat (12) @(negedge clk_500);
      chk("step_drain", 32'(exp_q.size()), 32'h0);

      // short glitches never reach the outputs
      step = 1'b1;
      repeat (3) @(negedge clk_500);
      step = 1'b0;
      repeat (15) @(negedge clk_500);
      inc = 1'b1;
      repeat (3) @(negedge clk_500);
      inc = 1'b0;
      repeat (15) @(negedge clk_500);
      chk("glitch_raddr", 32'(ddu_raddr), 32'h0);
      chk("glitch_cpu_clk", 32'(cpu_clk), 32'h0);

      // wrap in both directions, then simultaneous press
      press(1'b0, 1'b1);
      chk("wrap_dec_0", 32'(ddu_raddr), 32'hFF);
      press(1'b1, 1'b0);
      chk("wrap_inc_ff", 32'(ddu_raddr), 32'h00);
      press(1'b0, 1'b1);
      chk("wrap_dec_again", 32'(ddu_raddr), 32'hFF);
      press(1'b1, 1'b1);
      chk("inc_dec_same", 32'(ddu_raddr), 32'hFF);
      press(1'b1, 1'b0);

      // free run, step ignored, stop while cpu_clk is high
      @(negedge clk_500);
      n    = edge_n;
      cont = 1'b1;
      for (int e = n + 8; e <= n + 29; e++)
         push(e, ((e - n - 8) % 2) == 0, model);
      repeat (9) @(negedge clk_500);
      step = 1'b1;
      repeat (8) @(negedge clk_500);
      step = 1'b0;
      repeat (4) @(negedge clk_500);
      cont = 1'b0;
      repeat (30) @(negedge clk_500);
      chk("run_drain", 32'(exp_q.size()), 32'h0);
      chk("run_stopped_low", 32'(cpu_clk), 32'h0);

      // walk the address up to 0x37, checking led on the way
      for (int i = 0; i < 8'h37; i++) begin
         press(1'b1, 1'b0);
         if (model == 8'h12) begin
            chk("led_0x12", 32'(led), 32'h1241);
            pc_addr = 32'h0000_03FC;
            #1 chk("led_pc_change", 32'(led), 32'h12FF);
            pc_addr = 32'h0000_0104;
         end
      end
      chk("addr_0x37", 32'(ddu_raddr), 32'h37);

      // asynchronous reset in the middle of a run high phase
      @(negedge clk_500);
      n    = edge_n;
      cont = 1'b1;
      for (int e = n + 8; e <= n + 12; e++)
         push(e, ((e - n - 8) % 2) == 0, model);
      repeat (12) @(negedge clk_500);
      chk("pre_reset_cpu_clk", 32'(cpu_clk), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_cpu_clk", 32'(cpu_clk), 32'h0);
      chk("async_reset_raddr", 32'(ddu_raddr), 32'h0);
      model = 8'h00;
      cont  = 1'b0;
      repeat (3) @(negedge clk_500);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk_500);
      chk("post_reset_idle", 32'(cpu_clk), 32'h0);
      chk("final_drain", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddu_run_ctrl.md
# ddu_run_ctrl

Debug-unit run controller on the initiator side of the CPU debug-display interface. Conditions the board's run/step/address buttons, produces the gated CPU clock (free-running or single-step), and maintains the 8-bit debug read address sent to the register file and data memory. Sits beside the seven-segment driver in the 500 Hz domain; the CPU pipeline runs entirely on its clock output.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 10: consecutive differing samples needed to accept an input change (20 ms at 500 Hz).
- ADDR_WIDTH, default 8: width of the debug read address.

Ports:
- clk_500  in  1  500 Hz system clock. One clock domain only.
- rst  in  1  Asynchronous, active-high reset.
- cont  in  1  Raw run switch (level): 1 = free-run, 0 = halted/step mode.
- step  in  1  Raw single-step button.
- inc  in  1  Raw address-increment button.
- dec  in  1  Raw address-decrement button.
- pc_addr  in  32  Current CPU PC, used for LED display only.
- cpu_clk  out  1  Registered gated CPU clock.
- ddu_raddr  out  ADDR_WIDTH  Debug read address for register file (low 5 bits) and data memory.
- led  out  16  {ddu_raddr[7:0], pc_addr[9:2]}, combinational.

## Operation
- Input conditioning, per raw input: 2-flop synchronizer, then debouncer. The debouncer holds a level and a counter; the counter clears whenever the synced sample equals the level and increments otherwise. When the sample has differed for DEBOUNCE_CYCLES consecutive edges, the level takes the sample and the counter clears.
- A registered rising-edge detector produces one-cycle pulses step_p, inc_p and dec_p. cont uses the debounced level only.
- Clock FSM. States:
  - IDLE: cpu_clk = 0.
  - RUN: cpu_clk toggles every edge, giving 250 Hz at 50 % duty.
  - STEP_HI: cpu_clk = 1 for exactly one cycle.
- FSM transitions:
  - IDLE -> RUN when cont = 1.
  - IDLE -> STEP_HI when cont = 0 and step_p = 1.
  - STEP_HI -> IDLE unconditionally.
  - RUN -> IDLE when cont = 0. cpu_clk is driven 0 on that edge, so a high phase is truncated to at most one cycle and no partial extra edge is produced.
- Step pulses in RUN or STEP_HI are dropped, not queued.
- Address counter:
  - inc_p alone: +1, wrapping 255 -> 0.
  - dec_p alone: -1, wrapping 0 -> 255.
  - inc_p and dec_p in the same cycle: no change.
  - Arithmetic is modulo 2^ADDR_WIDTH.
- Reset (async, any time, including mid-step or mid-run):
  - Outputs: cpu_clk = 0, ddu_raddr = 0.
  - Internals: state IDLE, synchronizers/debounce levels/counters/edge registers 0.
  - After reset release, a button held through reset counts as a new press once debounced.

## Timing
- Raw input changes before edge 0:
  - Sync output is valid after edge 1.
  - Debounced level flips at edge DEBOUNCE_CYCLES+1.
  - Pulse is high after edge DEBOUNCE_CYCLES+2.
  - Action (address update, or cpu_clk rise / FSM change) occurs at edge DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES samples are never observed at outputs.
- Single step: cpu_clk high for exactly 1 clk_500 cycle, then low for at least 1 cycle before any further step can take effect.
- cont switched to 1: the first cpu_clk rise is at the action edge, via IDLE -> RUN driving 1.
- All outputs except led are registered. led has zero latency from pc_addr / ddu_raddr.

## Structure
- Package ddu_pkg holds:
  - the FSM state enum (IDLE, RUN, STEP_HI);
  - default DEBOUNCE_CYCLES and ADDR_WIDTH constants;
  - debounce counter width, $clog2(DEBOUNCE_CYCLES)+1.
- Sub-module btn_debounce (synchronizer + debouncer + registered rise pulse), instantiated four times. For cont, only its level output is used.
- The top holds the FSM, the address counter and the led concatenation.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: assert rst mid-RUN with cpu_clk = 1 and ddu_raddr = 0x37 -> cpu_clk = 0 and ddu_raddr = 0x00 immediately; state IDLE after release.
- Single step: cont = 0; step high from edge 0 for 10 cycles -> cpu_clk high only between edges 7 and 8; exactly one rise.
- Debounce: step high for 3 cycles, then low -> cpu_clk never rises. inc high for 3 cycles -> ddu_raddr unchanged.
- Address wrap:
  - Starting from ddu_raddr = 0xFF, one inc press -> 0x00.
  - Then one dec press -> 0xFF.
  - inc and dec pressed in the same cycle -> no change.
- Free-run then stop:
  - cont = 1 -> cpu_clk toggles every edge from edge 7 on; step presses are ignored.
  - cont dropped while cpu_clk = 1 -> cpu_clk = 0 at the action edge and stays 0.
- LED: pc_addr = 0x0000_0104, ddu_raddr = 0x12 -> led = 0x1241.
